// File: rtl/serdes_pkg.sv
// Shared types and constants for the serdes TX/RX sequencer.
// State typedefs, parameter defaults and counter widths.
package serdes_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_SHIFT = 2'd2,
    TX_GAP   = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_SHIFT   = 2'd1,
    RX_CAPTURE = 2'd2
  } rx_state_t;

  localparam int BITS_DEF       = 8;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int CNT_W          = 4;
  localparam int FRAME_CNT_W    = 8;

endpackage

// File: rtl/serdes_rx_seq.sv
// RX sequencer: frame sync -> BITS shift-in cycles -> one capture cycle.
// Holds the captured byte until handshaked; flags dropped frames sticky.
//
// state      | meaning
// RX_IDLE    | waiting for rx_sof
// RX_SHIFT   | data_en asserted, BITS cycles
// RX_CAPTURE | sample ser_data_in into the holding register
module serdes_rx_seq
  import serdes_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_sof,
  input  logic [7:0] ser_data_in,
  input  logic       rx_ready,
  output logic       data_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_overrun,
  output logic       capture
);

  localparam logic [CNT_W-1:0] BITS_LD = CNT_W'(BITS - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_en = 1'b0;
    capture = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_sof) begin
          state_d = RX_SHIFT;
          cnt_d   = BITS_LD;
        end
      end
      RX_SHIFT: begin
        data_en = 1'b1;
        if (cnt_q == '0) state_d = RX_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RX_CAPTURE: begin
        capture = 1'b1;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A capture that meets an un-consumed byte drops the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_overrun <= 1'b0;
    end else if (capture) begin
      if (rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else begin
        rx_data  <= ser_data_in;
        rx_valid <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serdes_seq.sv
// Serdes TX/RX sequencer top: inline TX FSM plus serdes_rx_seq instance.
// Define SERDES_FRAME_CNT_EN to add tx_count/rx_count frame counters.
//
// state    | meaning
// TX_IDLE  | tx_ready high, waiting for a byte
// TX_LOAD  | par_en strobe for one cycle
// TX_SHIFT | ser_en for BITS cycles, tx_sof on the first
// TX_GAP   | GAP_CYCLES idle cycles before the next byte
module serdes_seq
  import serdes_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] data_8b_out,
  output logic       par_en,
  output logic       ser_en,
  output logic       tx_sof,
  input  logic       rx_sof,
  output logic       data_en,
  input  logic [7:0] ser_data_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overrun
`ifdef SERDES_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] tx_count,
  output logic [FRAME_CNT_W-1:0] rx_count
`endif
);

  localparam logic [CNT_W-1:0] BITS_LD = CNT_W'(BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              init_q;
  logic              shift_done;
  logic              rx_capture;

  // init_q keeps tx_ready low until the first clock out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      init_q      <= 1'b0;
      data_8b_out <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
      if (tx_valid && tx_ready) data_8b_out <= tx_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_ready   = 1'b0;
    par_en     = 1'b0;
    ser_en     = 1'b0;
    tx_sof     = 1'b0;
    shift_done = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_ready = init_q;
        if (tx_valid && init_q) state_d = TX_LOAD;
      end
      TX_LOAD: begin
        par_en  = 1'b1;
        state_d = TX_SHIFT;
        cnt_d   = BITS_LD;
      end
      TX_SHIFT: begin
        ser_en = 1'b1;
        tx_sof = (cnt_q == BITS_LD);
        if (cnt_q == '0) begin
          shift_done = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = TX_IDLE;
          end else begin
            state_d = TX_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TX_GAP: begin
        if (cnt_q == '0) state_d = TX_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = TX_IDLE;
    endcase
  end

  serdes_rx_seq #(.BITS(BITS)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_sof     (rx_sof),
    .ser_data_in(ser_data_in),
    .rx_ready   (rx_ready),
    .data_en    (data_en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_overrun (rx_overrun),
    .capture    (rx_capture)
  );

`ifdef SERDES_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (shift_done) tx_count <= tx_count + FRAME_CNT_W'(1);
      if (rx_capture) rx_count <= rx_count + FRAME_CNT_W'(1);
    end
  end
`else
  logic unused_frame_evt;
  assign unused_frame_evt = shift_done ^ rx_capture;
`endif

endmodule
